// File: rtl/rc_osc_monitor.sv
// rc_osc_monitor: enables the on-chip RC oscillator, waits out its startup time,
// then counts its rising edges over back-to-back windows of system clock cycles
// and reports the count plus running/failed status.
module rc_osc_monitor #(
    parameter int WIN_W       = 16,
    parameter int CNT_W       = 12,
    parameter int STARTUP_CYC = 256
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [WIN_W-1:0] window,
    input  logic             osc_clk,
    output logic             osc_en,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             osc_ready,
    output logic             osc_fail,
    output logic [1:0]       state
);

    localparam int SU_W = $clog2(STARTUP_CYC + 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        START = 2'd1,
        MEAS  = 2'd2
    } st_t;

    st_t st, st_nx;

    logic             sync1, sync2, prev;
    logic             osc_edge;
    logic [SU_W-1:0]  su_cnt;
    logic [WIN_W-1:0] wcnt;
    logic [WIN_W-1:0] win_load;
    logic [CNT_W-1:0] ecnt;
    logic [CNT_W-1:0] ecnt_nx;

    // A zero window would never terminate, so it is run as a one-cycle window.
    assign win_load = (window == '0) ? WIN_W'(1) : window;
    assign osc_edge = sync2 & ~prev;
    // Edge counter next value, held at all-ones once saturated.
    assign ecnt_nx  = ecnt + CNT_W'(osc_edge & ~(&ecnt));
    assign state    = st;

    // Synchronize osc_clk and keep one older sample for rising-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= osc_clk;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) st <= OFF;
        else         st <= st_nx;
    end

    // Next state: dropping enable always returns to OFF, from any active state.
    always_comb begin
        st_nx = st;
        case (st)
            OFF:     if (enable) st_nx = START;
            START:   if (!enable) st_nx = OFF;
                     else if (su_cnt == SU_W'(1)) st_nx = MEAS;
            MEAS:    if (!enable) st_nx = OFF;
            default: st_nx = OFF;
        endcase
    end

    // Startup/window/edge counters and the reported results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            osc_en      <= 1'b0;
            su_cnt      <= '0;
            wcnt        <= '0;
            ecnt        <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            osc_ready   <= 1'b0;
            osc_fail    <= 1'b0;
        end else begin
            osc_en      <= (st_nx != OFF);
            count_valid <= 1'b0;
            case (st)
                OFF: begin
                    if (st_nx == START) begin
                        su_cnt   <= SU_W'(STARTUP_CYC);
                        osc_fail <= 1'b0;
                    end
                end
                START: begin
                    su_cnt <= su_cnt - SU_W'(1);
                    if (st_nx == MEAS) begin
                        wcnt <= win_load;
                        ecnt <= '0;
                    end
                end
                MEAS: begin
                    // A window cut short by enable dropping is simply discarded.
                    if (enable) begin
                        if (wcnt == WIN_W'(1)) begin
                            count       <= ecnt_nx;
                            count_valid <= 1'b1;
                            if (ecnt_nx == '0) begin
                                osc_fail  <= 1'b1;
                                osc_ready <= 1'b0;
                            end else begin
                                osc_ready <= 1'b1;
                            end
                            ecnt <= '0;
                            wcnt <= win_load;
                        end else begin
                            wcnt <= wcnt - WIN_W'(1);
                            ecnt <= ecnt_nx;
                        end
                    end
                end
                default: ;
            endcase
            if (st_nx == OFF) osc_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rc_osc_monitor.sv
// Testbench for rc_osc_monitor: randomized oscillator/window stimulus, an
// interval-level reference model, and a scoreboard that checks every count_valid.
module tb_rc_osc_monitor;

    localparam int WIN_W = 16;
    localparam int CNT_W = 12;
    localparam int SU    = 256;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             enable = 1'b0;
    logic [WIN_W-1:0] window = '0;
    logic             osc_clk = 1'b0;
    logic             osc_en;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             osc_ready;
    logic             osc_fail;
    logic [1:0]       state;

    rc_osc_monitor #(.WIN_W(WIN_W), .CNT_W(CNT_W), .STARTUP_CYC(SU)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .window(window),
        .osc_clk(osc_clk), .osc_en(osc_en), .count(count),
        .count_valid(count_valid), .osc_ready(osc_ready), .osc_fail(osc_fail),
        .state(state)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Oscillator source: 0 = stuck low, 1 = square wave, 2 = random level per cycle.
    int osc_mode = 0;
    int osc_half = 1;
    int osc_ph   = 0;
    initial forever begin
        @(negedge clk);
        case (osc_mode)
            0: osc_clk = 1'b0;
            1: begin
                osc_ph++;
                if (osc_ph >= osc_half) begin
                    osc_ph  = 0;
                    osc_clk = ~osc_clk;
                end
            end
            default: osc_clk = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference model: tracks phase (off/startup/measuring), remaining cycles,
    // and the number of synchronized rising edges seen in the current window.
    typedef struct {
        int cnt;
        bit rdy;
        bit fl;
    } exp_t;
    exp_t q[$];

    int m_mode = 0;      // 0 off, 1 startup, 2 measuring
    int m_left = 0;
    int m_wl   = 0;
    int m_acc  = 0;
    int m_cnt  = 0;
    bit m_rdy  = 0;
    bit m_fail = 0;
    bit m_cv   = 0;
    bit h1 = 0, h2 = 0, h3 = 0;   // osc samples from 1, 2, 3 cycles back
    bit m_e;

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_mode = 0; m_left = 0; m_wl = 0; m_acc = 0; m_cnt = 0;
            m_rdy = 0; m_fail = 0; m_cv = 0; h1 = 0; h2 = 0; h3 = 0;
            q.delete();
        end else begin
            // an osc rising edge reaches the counting logic two samples late
            m_e = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = osc_clk;
            m_cv = 0;
            case (m_mode)
                0: if (enable) begin
                    m_mode = 1; m_left = SU; m_fail = 0;
                end
                1: if (!enable) begin
                    m_mode = 0; m_rdy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 2;
                        m_wl   = (window == 0) ? 1 : int'(window);
                        m_acc  = 0;
                    end
                end
                default: if (!enable) begin
                    m_mode = 0; m_rdy = 0;
                end else begin
                    m_acc += int'(m_e);
                    m_wl--;
                    if (m_wl == 0) begin
                        m_cnt = (m_acc > CMAX) ? CMAX : m_acc;
                        m_cv  = 1;
                        if (m_cnt == 0) begin
                            m_fail = 1; m_rdy = 0;
                        end else begin
                            m_rdy = 1;
                        end
                        q.push_back('{m_cnt, m_rdy, m_fail});
                        m_acc = 0;
                        m_wl  = (window == 0) ? 1 : int'(window);
                    end
                end
            endcase
        end
    end

    // Monitor: every cycle compare visible status with the model; on each
    // count_valid pop the scoreboard and check the reported result.
    exp_t x;
    initial forever begin
        @(negedge clk);
        nvec++;
        if ({state, osc_en, osc_ready, osc_fail, count_valid, count} !==
            {2'(m_mode), (m_mode != 0), m_rdy, m_fail, m_cv, CNT_W'(m_cnt)}) begin
            nmis++;
            $display("FAIL status @%0t: got st=%0d en=%0b rdy=%0b fail=%0b cv=%0b cnt=%0d want st=%0d en=%0b rdy=%0b fail=%0b cv=%0b cnt=%0d",
                     $time, state, osc_en, osc_ready, osc_fail, count_valid, count,
                     m_mode, (m_mode != 0), m_rdy, m_fail, m_cv, m_cnt);
        end
        if (count_valid === 1'b1) begin
            nvec++;
            if (q.size() == 0) begin
                nmis++;
                $display("FAIL unexpected_valid @%0t: got count_valid=1 cnt=%0d want no result", $time, count);
            end else begin
                x = q.pop_front();
                if (count !== CNT_W'(x.cnt) || osc_ready !== x.rdy || osc_fail !== x.fl) begin
                    nmis++;
                    $display("FAIL result @%0t: got cnt=%0d rdy=%0b fail=%0b want cnt=%0d rdy=%0b fail=%0b",
                             $time, count, osc_ready, osc_fail, x.cnt, x.rdy, x.fl);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    int saved;
    bit hit;

    // Stimulus sequence.
    initial begin
        window   = 16'd10000;
        osc_mode = 1;
        osc_half = 500;
        resetn   = 1'b0;
        cyc(3);
        chk("reset_outputs", {osc_en, count, count_valid, osc_ready, osc_fail, state}, 0);
        resetn = 1'b1;
        cyc(4);
        chk("idle_off", state, 0);

        // nominal: 1000-cycle oscillator, 10000-cycle windows
        enable = 1'b1;
        cyc(1);
        chk("osc_en_after_enable", osc_en, 1);
        cyc(SU - 1);
        chk("still_start", state, 1);
        cyc(1);
        chk("meas_after_startup", state, 2);
        cyc(2 * 10000 + 20);
        chk("nominal_count_range", int'(count >= 9 && count <= 11), 1);
        chk("nominal_ready", osc_ready, 1);
        chk("nominal_fail", osc_fail, 0);

        // asynchronous reset in the middle of a run
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk("async_reset_outputs", {osc_en, count, count_valid, osc_ready, osc_fail, state}, 0);
        enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        cyc(3);
        chk("off_after_reset", state, 0);

        // stuck oscillator, then recovery
        osc_mode = 0;
        window   = 16'd5000;
        enable   = 1'b1;
        cyc(SU + 5000 + 5);
        chk("stuck_count", count, 0);
        chk("stuck_fail", osc_fail, 1);
        chk("stuck_ready", osc_ready, 0);
        osc_mode = 1;
        osc_half = 50;
        cyc(5000 + 10);
        chk("recover_ready", osc_ready, 1);
        chk("recover_fail_sticky", osc_fail, 1);

        // abort exactly on the last cycle of a window
        window = 16'd300;
        hit = 0;
        for (int i = 0; i < 6000 && !hit; i++) begin
            cyc(1);
            if (m_mode == 2 && m_wl == 1) hit = 1;
        end
        chk("abort_reached_last_cycle", int'(hit), 1);
        saved  = m_cnt;
        enable = 1'b0;
        cyc(1);
        chk("abort_no_valid", count_valid, 0);
        chk("abort_count_held", count, saved);
        chk("abort_osc_en_low", osc_en, 0);
        chk("abort_state_off", state, 0);
        cyc(3);

        // restart: fail cleared on startup entry, full startup repeats
        window   = 16'd17000;
        osc_half = 2;
        enable   = 1'b1;
        cyc(1);
        chk("restart_fail_cleared", osc_fail, 0);
        chk("restart_state_start", state, 1);
        cyc(SU - 1);
        chk("restart_still_start", state, 1);
        cyc(1);
        chk("restart_meas", state, 2);

        // saturation: 4-cycle oscillator over a 17000-cycle window
        cyc(100);
        window = '0;
        cyc(17000 - 100);
        chk("sat_valid", count_valid, 1);
        chk("sat_count", count, CMAX);

        // zero window: one-cycle windows back to back
        osc_mode = 2;
        cyc(5);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("win0_valid", count_valid, 1);
            chk("win0_count_range", int'(count <= 1), 1);
        end

        // random short windows, random edges, occasional enable drops
        for (int i = 0; i < 3000; i++) begin
            window = WIN_W'($urandom_range(0, 12));
            if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            cyc(1);
        end

        enable = 1'b0;
        cyc(5);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
